// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//
// Buffers instructions from a loader in a small FIFO and hands them to a core
// one at a time, holding each on coreInstruction until the core reports
// completion. Completion with further entries buffered issues the next one
// on the same edge, so there is no bubble between instructions.
//
// Optional feature (macro SEQ_TIMEOUT_EN): a wait counter abandons an
// instruction that has sat in WAIT for TIMEOUT cycles and sets the sticky
// timeoutFlag. Without the macro, WAIT persists until completion and
// timeoutFlag is tied to 0.
//
// Parameters:
//   DEPTH   - FIFO entries, power of two in 2..16
//   TIMEOUT - WAIT cycles before an instruction is abandoned, 2..255
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   inInstruction   in   [31:0] instruction from loader
//   inValid         in   loader offers inInstruction
//   inReady         out  FIFO not full (registered state only)
//   flush           in   discard buffered and in-flight instructions
//   coreInstruction out  [31:0] registered instruction presented to core
//   coreValid       out  high in ISSUE or WAIT
//   coreComplete    in   core finished the presented instruction
//   busy            out  not IDLE, or FIFO non-empty
//   fifoCount       out  buffered entries, excluding the in-flight one
//   issuedCount     out  [31:0] completed instructions (wraps)
//   stallCycles     out  [31:0] cycles spent waiting on the core (wraps)
//   timeoutFlag     out  sticky, an instruction was abandoned
// ---------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              inInstruction,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic                     flush,
    output logic [31:0]              coreInstruction,
    output logic                     coreValid,
    input  logic                     coreComplete,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic [31:0]              issuedCount,
    output logic [31:0]              stallCycles,
    output logic                     timeoutFlag
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       issued_q, issued_d;
    logic [31:0]       stall_q, stall_d;

    logic push;
    logic pop;
    logic retire;
    logic fifo_nonempty;
    logic timeout_hit;

    assign fifo_nonempty = (count_q != '0);
    // Full blocks the push even when a pop happens on the same edge.
    assign inReady       = (count_q < FullCnt);
    assign push          = inValid && inReady && !flush;

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    // Fires on the TIMEOUT-th cycle spent in WAIT.
    assign timeout_hit = (state_q == StWait) && !coreComplete &&
                         (wait_cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (flush || pop) begin
            wait_cnt_d = '0;
        end else if (state_q == StWait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (!flush && timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeoutFlag = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeoutFlag = 1'b0;
`endif

    // Sequencer next state: flush overrides everything but reset, and a
    // timeout retires the instruction exactly like a completion without
    // counting it.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        issued_d = issued_q;
        stall_d  = stall_q;
        pop      = 1'b0;
        retire   = 1'b0;

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        state_d = StIssue;
                    end
                end
                StIssue, StWait: begin
                    if (coreComplete) begin
                        issued_d = issued_q + 32'd1;
                        retire   = 1'b1;
                    end else if (timeout_hit) begin
                        retire   = 1'b1;
                    end else begin
                        state_d  = StWait;
                        stall_d  = stall_q + 32'd1;
                    end
                    if (retire) begin
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            state_d = StIssue;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (pop) begin
            instr_d = mem_q[rd_ptr_q];
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    // Storage array needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= inInstruction;
        end
    end

    assign coreInstruction = instr_q;
    assign coreValid       = (state_q == StIssue) || (state_q == StWait);
    assign busy            = (state_q != StIdle) || fifo_nonempty;
    assign fifoCount       = count_q;
    assign issuedCount     = issued_q;
    assign stallCycles     = stall_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inInstruction;
    logic        inValid;
    logic        inReady;
    logic        flush;
    logic [31:0] coreInstruction;
    logic        coreValid;
    logic        coreComplete;
    logic        busy;
    logic [2:0]  fifoCount;
    logic [31:0] issuedCount;
    logic [31:0] stallCycles;
    logic        timeoutFlag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    instruction_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inInstruction   (inInstruction),
        .inValid         (inValid),
        .inReady         (inReady),
        .flush           (flush),
        .coreInstruction (coreInstruction),
        .coreValid       (coreValid),
        .coreComplete    (coreComplete),
        .busy            (busy),
        .fifoCount       (fifoCount),
        .issuedCount     (issuedCount),
        .stallCycles     (stallCycles),
        .timeoutFlag     (timeoutFlag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".coreValid"}, 32'(coreValid), 32'd0);
        check({tag, ".coreInstr"}, coreInstruction, 32'd0);
        check({tag, ".fifoCount"}, 32'(fifoCount), 32'd0);
        check({tag, ".issued"}, issuedCount, 32'd0);
        check({tag, ".stall"}, stallCycles, 32'd0);
        check({tag, ".timeout"}, 32'(timeoutFlag), 32'd0);
        check({tag, ".inReady"}, 32'(inReady), 32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    logic [31:0] b_vec [4];
    logic [31:0] d_vec [6];

    initial begin
        b_vec[0] = 32'h1111_0001; b_vec[1] = 32'h2222_0002;
        b_vec[2] = 32'h3333_0003; b_vec[3] = 32'h4444_0004;
        for (int i = 0; i < 6; i++) d_vec[i] = 32'hD000_0000 + 32'(i);

        reset = 1'b1; inInstruction = '0; inValid = 1'b0; flush = 1'b0; coreComplete = 1'b0;
        #1;
        tick(); tick();
        reset = 1'b0;
        check_reset_values("rst");

        // Single instruction, core completes immediately.
        coreComplete = 1'b1;
        inValid = 1'b1; inInstruction = 32'h0050_0093;
        tick();
        inValid = 1'b0;
        check("t1.count_after_push", 32'(fifoCount), 32'd1);
        check("t1.valid_after_push", 32'(coreValid), 32'd0);
        tick();
        check("t1.valid", 32'(coreValid), 32'd1);
        check("t1.instr", coreInstruction, 32'h0050_0093);
        tick();
        check("t1.idle", 32'(coreValid), 32'd0);
        check("t1.issued", issuedCount, 32'd1);
        check("t1.busy", 32'(busy), 32'd0);

        // Four back-to-back instructions, write pointer wraps.
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1; inInstruction = b_vec[i];
            tick();
            if (i > 0) check($sformatf("t2.order%0d", i - 1), coreInstruction, b_vec[i-1]);
        end
        inValid = 1'b0;
        tick();
        check("t2.order3", coreInstruction, b_vec[3]);
        check("t2.valid3", 32'(coreValid), 32'd1);
        tick();
        check("t2.idle", 32'(coreValid), 32'd0);
        check("t2.issued", issuedCount, 32'd5);
        check("t2.stall", stallCycles, 32'd0);

        // Three cycles without completion.
        coreComplete = 1'b0;
        inValid = 1'b1; inInstruction = 32'hCAFE_0001;
        tick();
        inValid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3.hold%0d", i), coreInstruction, 32'hCAFE_0001);
            check($sformatf("t3.valid%0d", i), 32'(coreValid), 32'd1);
        end
        coreComplete = 1'b1;
        tick();
        check("t3.stall", stallCycles, 32'd3);
        check("t3.issued", issuedCount, 32'd6);
        check("t3.idle", 32'(coreValid), 32'd0);

        // Fill FIFO behind a waiting instruction, pop while full, then flush.
        coreComplete = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1; inInstruction = d_vec[i];
            tick();
        end
        check("t4.full_count", 32'(fifoCount), 32'd4);
        check("t4.full_ready", 32'(inReady), 32'd0);
        check("t4.stall_fill", stallCycles, 32'd6);
        inInstruction = d_vec[5];
        tick();
        check("t4.no_overwrite", 32'(fifoCount), 32'd4);
        check("t4.hold_d0", coreInstruction, d_vec[0]);
        coreComplete = 1'b1;
        tick();
        check("t4.pop_while_full", 32'(fifoCount), 32'd3);
        check("t4.next_d1", coreInstruction, d_vec[1]);
        check("t4.issued_pop", issuedCount, 32'd7);
        coreComplete = 1'b0; inValid = 1'b0;
        tick();
        check("t4.stall_wait", stallCycles, 32'd8);
        flush = 1'b1; coreComplete = 1'b1; inValid = 1'b1;
        tick();
        flush = 1'b0; coreComplete = 1'b0; inValid = 1'b0;
        check("t4.flush_count", 32'(fifoCount), 32'd0);
        check("t4.flush_valid", 32'(coreValid), 32'd0);
        check("t4.flush_issued", issuedCount, 32'd7);
        check("t4.flush_stall", stallCycles, 32'd8);
        check("t4.flush_busy", 32'(busy), 32'd0);
        tick();
        check("t4.post_flush_valid", 32'(coreValid), 32'd0);

        // Reset in the middle of WAIT with a buffered entry.
        inValid = 1'b1; inInstruction = 32'hEEEE_0000;
        tick();
        inInstruction = 32'hEEEE_0001;
        tick();
        inValid = 1'b0;
        tick();
        check("t5.in_wait", 32'(coreValid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("t5");
        tick();
        check("t5.stays_idle", 32'(coreValid), 32'd0);

        // Unanswered instruction followed by a second one.
        inValid = 1'b1; inInstruction = 32'hF000_0000;
        tick();
        inInstruction = 32'hF000_0001;
        tick();
        inValid = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 16; i++) tick();
        check("t6.no_timeout_yet", 32'(timeoutFlag), 32'd0);
        check("t6.still_f0", coreInstruction, 32'hF000_0000);
        tick();
        check("t6.timeout", 32'(timeoutFlag), 32'd1);
        check("t6.next_f1", coreInstruction, 32'hF000_0001);
        check("t6.issued", issuedCount, 32'd0);
        check("t6.valid", 32'(coreValid), 32'd1);
`else
        for (int i = 0; i < 100; i++) tick();
        check("t6.still_valid", 32'(coreValid), 32'd1);
        check("t6.still_f0", coreInstruction, 32'hF000_0000);
        check("t6.stall", stallCycles, 32'd100);
        check("t6.timeout", 32'(timeoutFlag), 32'd0);
        check("t6.count", 32'(fifoCount), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
